vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, successor to the fixed 640x480 sync block. It produces the sync, blanking and pixel-coordinate signals for any VESA-style mode from a single system clock. Pixel rate comes from an internal clock-enable prescaler, so no derived clocks are needed. It sits between the system clock and the pixel/framebuffer logic. Downstream logic uses `pix_tick`, `line_start` and `frame_start` to fetch pixels and to swap buffers at frame boundaries.

---
 rtl/vga_timing_gen_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 27 ++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing description for the VGA raster generator: mode record,
// the standard 640x480@60 mode and a helper for per-axis totals.
package vga_pkg;

    // Porch/sync/active lengths of one video mode (pixels and lines).
    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    // Total length of one axis: active + front porch + sync + back porch.
    function automatic int unsigned vga_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis. Advances on inc and
// flags the terminal step (inc while at TOTAL-1) on wrap.
module vga_axis_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned CW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    assign wrap = inc && (count == LAST);

    // Position register: clear on reset, step or wrap on inc, else hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. A clock-enable prescaler sets
// the pixel rate; h/v axis counters track the raster position and all
// outputs are decoded from the counters and registered one clk later.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          blank_n,
    output logic          sync_n,
    output logic [CW-1:0] posx,
    output logic [CW-1:0] posy,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam longint unsigned CNT_RANGE = longint'(1) << CW;

    localparam int unsigned H_SS = H_ACTIVE + H_FP;
    localparam int unsigned H_SE = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SS = V_ACTIVE + V_FP;
    localparam int unsigned V_SE = V_ACTIVE + V_FP + V_SYNC;

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (longint'(H_TOTAL - 1) >= CNT_RANGE) begin : g_bad_h_width
        $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
    end
    if (longint'(V_TOTAL - 1) >= CNT_RANGE) begin : g_bad_v_width
        $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
    end

    logic [DW-1:0] div_cnt;
    logic          pix_adv;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          h_wrap;
    logic          v_wrap;

    logic          h_act;
    logic          v_act;
    logic          hs_act;
    logic          vs_act;
    logic          first_clk;

    // Pixel prescaler: cycles 0..CLK_DIV-1 while enabled, holds its phase when not.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
    end

    assign pix_adv = en && (div_cnt == DIV_LAST);

    vga_axis_counter #(
        .TOTAL(H_TOTAL),
        .CW   (CW)
    ) u_hcnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (pix_adv),
        .count(hcount),
        .wrap (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL),
        .CW   (CW)
    ) u_vcnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (h_wrap),
        .count(vcount),
        .wrap (v_wrap)
    );

    // Region decode from the current counter values (32-bit compares so a
    // sync window ending exactly at 2**CW cannot alias).
    always_comb begin
        h_act     = 32'(hcount) < H_ACTIVE;
        v_act     = 32'(vcount) < V_ACTIVE;
        hs_act    = (32'(hcount) >= H_SS) && (32'(hcount) < H_SE);
        vs_act    = (32'(vcount) >= V_SS) && (32'(vcount) < V_SE);
        first_clk = en && (div_cnt == '0);
    end

    // Output registers: every output lags the counters by exactly one clk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            blank_n     <= 1'b0;
            sync_n      <= 1'b1;
            posx        <= '0;
            posy        <= '0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= hs_act ? H_POL : ~H_POL;
            v_sync      <= vs_act ? V_POL : ~V_POL;
            blank_n     <= h_act && v_act;
            sync_n      <= 1'b1;
            posx        <= h_act ? hcount : '0;
            posy        <= v_act ? vcount : '0;
            pix_tick    <= first_clk;
            line_start  <= first_clk && (hcount == '0);
            frame_start <= first_clk && (hcount == '0) && (vcount == '0);
        end
    end

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default mode, a tiny mode for
// cycle-exact tables, and CLK_DIV=1 / CLK_DIV=4 variants.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en0;
    logic en_c;

    always #5 clk = ~clk;

    // dut0: defaults
    logic hs0, vs0, bl0, sn0, pt0, ls0, fs0;
    logic [10:0] px0, py0;
    // dut1: small mode, CLK_DIV=1, positive polarity, CW=4
    logic hs1, vs1, bl1, sn1, pt1, ls1, fs1;
    logic [3:0] px1, py1;
    // dut2: CLK_DIV=1
    logic hs2, vs2, bl2, sn2, pt2, ls2, fs2;
    logic [10:0] px2, py2;
    // dut3: CLK_DIV=4
    logic hs3, vs3, bl3, sn3, pt3, ls3, fs3;
    logic [10:0] px3, py3;

    vga_timing_gen dut0 (
        .clk(clk), .rst(rst), .en(en0),
        .h_sync(hs0), .v_sync(vs0), .blank_n(bl0), .sync_n(sn0),
        .posx(px0), .posy(py0), .pix_tick(pt0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CW(4)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en_c),
        .h_sync(hs1), .v_sync(vs1), .blank_n(bl1), .sync_n(sn1),
        .posx(px1), .posy(py1), .pix_tick(pt1), .line_start(ls1), .frame_start(fs1)
    );

    vga_timing_gen #(.CLK_DIV(1)) dut2 (
        .clk(clk), .rst(rst), .en(en_c),
        .h_sync(hs2), .v_sync(vs2), .blank_n(bl2), .sync_n(sn2),
        .posx(px2), .posy(py2), .pix_tick(pt2), .line_start(ls2), .frame_start(fs2)
    );

    vga_timing_gen #(.CLK_DIV(4)) dut3 (
        .clk(clk), .rst(rst), .en(en_c),
        .h_sync(hs3), .v_sync(vs3), .blank_n(bl3), .sync_n(sn3),
        .posx(px3), .posy(py3), .pix_tick(pt3), .line_start(ls3), .frame_start(fs3)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    bit phase1 = 1'b0;
    bit prev_hs0;
    int ls0_at = 0, ls2_at = 0, ls3_at = 0, hs_fall = 0, hs_rise = 0;
    int pt2_cnt = 0, pt3_cnt = 0;

    typedef struct {
        int k;
        int posx;
        int posy;
        int blank;
        int hs;
        int vs;
        int ls;
        int fs;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clk edge, sample #1 later, and record phase-1 timing events.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (phase1) begin
            if (ls0 && cyc > 1 && ls0_at == 0) ls0_at = cyc;
            if (ls2 && cyc > 1 && ls2_at == 0) ls2_at = cyc;
            if (ls3 && cyc > 1 && ls3_at == 0) ls3_at = cyc;
            if (prev_hs0 && !hs0 && hs_fall == 0) hs_fall = cyc;
            if (!prev_hs0 && hs0 && hs_rise == 0) hs_rise = cyc;
            if (cyc >= 51 && cyc <= 150) begin
                pt2_cnt += int'(pt2);
                pt3_cnt += int'(pt3);
            end
        end
        prev_hs0 = hs0;
    endtask

    initial begin
        int c0;
        int found;
        int bad_pulse;
        int bad_pos;
        int bad_lvl;

        // Small mode (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1): clk k shows
        // h=(k-1)%8, v=((k-1)/8)%6; hsync on h=5,6; vsync on v=4.
        //            k  posx posy blank hs vs ls fs
        tbl[0]  = '{ 1, 0, 0, 1, 0, 0, 1, 1};
        tbl[1]  = '{ 2, 1, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{ 3, 2, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{ 4, 3, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{ 5, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{ 6, 0, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{ 7, 0, 0, 0, 1, 0, 0, 0};
        tbl[7]  = '{ 8, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{ 9, 0, 1, 1, 0, 0, 1, 0};
        tbl[9]  = '{11, 2, 1, 1, 0, 0, 0, 0};
        tbl[10] = '{17, 0, 2, 1, 0, 0, 1, 0};
        tbl[11] = '{25, 0, 0, 0, 0, 0, 1, 0};
        tbl[12] = '{33, 0, 0, 0, 0, 1, 1, 0};
        tbl[13] = '{38, 0, 0, 0, 1, 1, 0, 0};
        tbl[14] = '{41, 0, 0, 0, 0, 0, 1, 0};
        tbl[15] = '{49, 0, 0, 1, 0, 0, 1, 1};
        tbl[16] = '{50, 1, 0, 1, 0, 0, 0, 0};

        rst  = 1'b0;
        en0  = 1'b1;
        en_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_hsync0", int'(hs0), 1);
        chk("rst_vsync0", int'(vs0), 1);
        chk("rst_blank0", int'(bl0), 0);
        chk("rst_syncn0", int'(sn0), 1);
        chk("rst_posx0", int'(px0), 0);
        chk("rst_posy0", int'(py0), 0);
        chk("rst_pulses0", int'({pt0, ls0, fs0}), 0);
        chk("rst_hsync1", int'(hs1), 0);
        chk("rst_vsync1", int'(vs1), 0);
        prev_hs0 = hs0;

        // Release: next edge is clk 1
        rst    = 1'b1;
        cyc    = 0;
        phase1 = 1'b1;
        tick();
        chk("c1_frame_start0", int'(fs0), 1);
        chk("c1_line_start0", int'(ls0), 1);
        chk("c1_pix_tick0", int'(pt0), 1);
        chk("c1_blank0", int'(bl0), 1);
        chk("c1_frame_start3", int'(fs3), 1);

        // Small-mode table
        for (int i = 0; i < 17; i++) begin
            while (cyc < tbl[i].k) tick();
            chk($sformatf("k%0d_posx", tbl[i].k), int'(px1), tbl[i].posx);
            chk($sformatf("k%0d_posy", tbl[i].k), int'(py1), tbl[i].posy);
            chk($sformatf("k%0d_blank", tbl[i].k), int'(bl1), tbl[i].blank);
            chk($sformatf("k%0d_hsync", tbl[i].k), int'(hs1), tbl[i].hs);
            chk($sformatf("k%0d_vsync", tbl[i].k), int'(vs1), tbl[i].vs);
            chk($sformatf("k%0d_line_start", tbl[i].k), int'(ls1), tbl[i].ls);
            chk($sformatf("k%0d_frame_start", tbl[i].k), int'(fs1), tbl[i].fs);
        end

        while (cyc < 3300) tick();
        phase1 = 1'b0;

        chk("hsync_fall_clk", hs_fall, 1313);
        chk("hsync_rise_clk", hs_rise, 1505);
        chk("line2_start_clk_div2", ls0_at, 1601);
        chk("line2_start_clk_div1", ls2_at, 801);
        chk("line2_start_clk_div4", ls3_at, 3201);
        chk("pix_tick_cnt_div1", pt2_cnt, 100);
        chk("pix_tick_cnt_div4", pt3_cnt, 25);
        // clk 3300: div2 shows h=49 v=2; div4 shows h=24 v=1
        chk("c3300_posx0", int'(px0), 49);
        chk("c3300_posy0", int'(py0), 2);
        chk("c3300_posx3", int'(px3), 24);
        chk("c3300_posy3", int'(py3), 1);

        // Freeze at hcount=100
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            tick();
            if (px0 == 11'd100 && pt0) found = 1;
        end
        chk("find_x100", found, 1);
        c0 = cyc;
        en0 = 1'b0;
        bad_pulse = 0;
        bad_pos = 0;
        bad_lvl = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pt0 || ls0 || fs0) bad_pulse++;
            if (px0 != 11'd100) bad_pos++;
            if (!bl0 || !hs0) bad_lvl++;
        end
        chk("freeze_pulses", bad_pulse, 0);
        chk("freeze_posx", bad_pos, 0);
        chk("freeze_levels", bad_lvl, 0);
        en0 = 1'b1;
        tick();
        chk("resume_posx_a", int'(px0), 100);
        chk("resume_tick_a", int'(pt0), 0);
        tick();
        chk("resume_posx_b", int'(px0), 101);
        chk("resume_tick_b", int'(pt0), 1);
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            tick();
            if (ls0) found = 1;
        end
        chk("freeze_line_delay", cyc - c0, 1410);

        // Reset mid-line at hcount=300
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            tick();
            if (px0 == 11'd300 && pt0) found = 1;
        end
        chk("find_x300", found, 1);
        chk("pre_rst_posy0_nonzero", int'(py0 != 11'd0), 1);
        rst = 1'b0;
        tick();
        chk("mid_rst_hsync0", int'(hs0), 1);
        chk("mid_rst_vsync0", int'(vs0), 1);
        chk("mid_rst_blank0", int'(bl0), 0);
        chk("mid_rst_posx0", int'(px0), 0);
        chk("mid_rst_posy0", int'(py0), 0);
        chk("mid_rst_pulses0", int'({pt0, ls0, fs0}), 0);
        chk("mid_rst_syncn0", int'(sn0), 1);
        chk("mid_rst_blank1", int'(bl1), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_frame_start0", int'(fs0), 1);
        chk("post_rst_blank0", int'(bl0), 1);
        chk("post_rst_posx0", int'(px0), 0);
        tick();
        chk("post_rst_tick_off0", int'(pt0), 0);
        chk("post_rst_fs_off0", int'(fs0), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
